ppu_fetch_unit: RTL
===================

Name: ppu_fetch_unit

Overview:
- Instruction-fetch stage of the PPU pipeline, sitting directly upstream of the decode/control unit.
- Holds the PC and issues one word fetch at a time to instruction memory over a req/valid handshake.
- Delivers instruction + PC to decode through a valid/ready output register backed by a one-entry hold buffer.
- Accepts branch/jump redirects from decode and discards wrong-path words, including a response still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high with imem_addr stable until imem_valid.
- imem_addr  out  ADDR_W  word address of the request; bits [1:0] always 0.
- imem_rdata  in  32  returned instruction word.
- imem_valid  in  1  one-cycle response strobe; may arrive in the request cycle or any later cycle.
- id_ready  in  1  decode can accept if_instr this cycle.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  instruction word to decode.
- if_pc  out  ADDR_W  address of if_instr.
- redirect_valid  in  1  one-cycle pulse from decode: a taken branch/jump.
- redirect_target  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 00.

Behaviour:
- Reset (async assert, sync release):
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=32'h0 (NOP), if_pc=RESET_PC.
  - Hold buffer empty; state=FETCH.
  - imem_req rises on the first clk edge after reset_n releases.
  - Reset asserted mid-fetch abandons the outstanding request; no response is captured after release.
- Transfer rule: decode consumes a word when if_valid && id_ready. The output register is free when !if_valid || id_ready.
- State FETCH (imem_req=1, imem_addr=fetch_addr):
  - redirect_valid && imem_valid: drop the word, fetch_addr<=target, clear if_valid and buffer, stay FETCH.
  - redirect_valid && !imem_valid: clear if_valid and buffer, latch target, go to DROP.
  - imem_valid, output free: if_instr<=rdata, if_pc<=fetch_addr, if_valid<=1, fetch_addr+=4, stay FETCH.
  - imem_valid, output occupied: buffer<=rdata/fetch_addr, fetch_addr+=4, go to HOLD.
  - Otherwise: if a word was consumed, if_valid<=0.
- State HOLD (imem_req=0):
  - redirect_valid: clear if_valid and buffer, fetch_addr<=target, go to FETCH.
  - id_ready: output register<=buffer (if_valid stays 1), buffer empty, go to FETCH.
- State DROP (imem_req=1, imem_addr = stale address held stable, protocol preserved):
  - imem_valid: discard the word, fetch_addr<=latched target, go to FETCH.
  - A new redirect_valid in DROP overwrites the latched target; the last redirect wins.
  - If redirect_valid and imem_valid occur in the same cycle in DROP, the new target is used.
- Redirect has priority over everything. No wrong-path word ever appears with if_valid=1 after the redirect cycle.
- Latency: a word is visible on if_instr the cycle after imem_valid. Sustained throughput is one word per cycle when memory answers in the request cycle and id_ready=1.
- PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0 silently.
- Outputs are registered: if_valid, if_instr and if_pc change only on clk edges or reset.
- One request is outstanding at a time; the block never has more than 2 words held (output register + buffer).

Test Plan:
- Reset release, memory returns 32'h2408_0005 same cycle at addr 0 -> if_valid=1, if_pc=0, if_instr=32'h2408_0005 next cycle; imem_addr=4.
- id_ready=0 while two words (addr 0, 4) return -> state HOLD, imem_req=0, if_pc stays 0. Raise id_ready -> if_pc=4 next cycle, then fetch resumes at 8.
- Redirect to 32'h0000_0103 while fetch of 8 is pending, memory answers 3 cycles later -> imem_addr stays 8 until imem_valid. That word is dropped. Next request is at 32'h0000_0100; first delivered if_pc=32'h100.
- Redirect to 0x40 in the same cycle as imem_valid for addr 0x10 -> word dropped, if_valid=0, next imem_addr=0x40.
- Two redirects (0x200, then 0x300) during DROP -> first delivered if_pc=0x300.
- reset_n low mid-HOLD -> immediately if_valid=0, if_instr=0, imem_req=0. After release, first fetch at RESET_PC.

Source files
------------

// File: rtl/ppu_fetch_unit.sv
// Purpose : PPU instruction fetch; owns the PC, issues one word fetch at a time, feeds decode.
// Latency : a word appears on if_instr the cycle after imem_valid; 1 word/cycle sustained.
// Backpr. : id_ready low parks one extra word in a hold buffer and drops imem_req until drained.
//
// Ports:
//   clk, reset_n                 pipeline clock, async active-low reset
//   imem_req/imem_addr           fetch request, address held stable until imem_valid
//   imem_rdata/imem_valid        one-cycle response strobe with the instruction word
//   if_valid/if_instr/if_pc      registered instruction + PC towards decode
//   id_ready                     decode accepts if_instr this cycle
//   redirect_valid/_target       taken branch/jump from decode; flushes the fetch stage
module ppu_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] START_PC   = RESET_PC & ALIGN_MASK;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] drop_tgt_q, drop_tgt_d;
    logic              req_en_q;
    logic              out_vld_q, out_vld_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [31:0]       buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;

    logic              rsp;
    logic              consume;
    logic              out_free;
    logic [ADDR_W-1:0] tgt;

    // req_en_q keeps imem_req low for the first cycle out of reset, so the
    // first request rises on the first edge after release.
    assign imem_req  = req_en_q && (state_q != ST_HOLD);
    // In DROP fetch_addr_q still holds the stale address; the redirect target
    // waits in drop_tgt_q so the request stays stable until it is answered.
    assign imem_addr = fetch_addr_q;

    // A strobe without an outstanding request carries nothing we asked for.
    assign rsp      = imem_valid && imem_req;
    assign consume  = out_vld_q && id_ready;
    assign out_free = !out_vld_q || id_ready;
    assign tgt      = redirect_target & ALIGN_MASK;

    assign if_valid = out_vld_q;
    assign if_instr = out_instr_q;
    assign if_pc    = out_pc_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        drop_tgt_d   = drop_tgt_q;
        out_vld_d    = out_vld_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    out_vld_d = 1'b0;
                    if (rsp || !imem_req) begin
                        // Nothing left in flight: retarget directly.
                        fetch_addr_d = tgt;
                    end else begin
                        // Wrong-path word still coming; wait it out in DROP.
                        drop_tgt_d = tgt;
                        state_d    = ST_DROP;
                    end
                end else if (rsp) begin
                    fetch_addr_d = fetch_addr_q + PC_STEP;
                    if (out_free) begin
                        out_vld_d   = 1'b1;
                        out_instr_d = imem_rdata;
                        out_pc_d    = fetch_addr_q;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = fetch_addr_q;
                        state_d     = ST_HOLD;
                    end
                end else if (consume) begin
                    out_vld_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    out_vld_d    = 1'b0;
                    fetch_addr_d = tgt;
                    state_d      = ST_FETCH;
                end else if (id_ready) begin
                    // Output word is consumed this cycle; buffered word replaces it.
                    out_vld_d   = 1'b1;
                    out_instr_d = buf_instr_q;
                    out_pc_d    = buf_pc_q;
                    state_d     = ST_FETCH;
                end
            end

            ST_DROP: begin
                if (redirect_valid) begin
                    drop_tgt_d = tgt;
                end
                if (consume) begin
                    out_vld_d = 1'b0;
                end
                if (rsp) begin
                    // Discard the stale word; the newest redirect wins.
                    fetch_addr_d = redirect_valid ? tgt : drop_tgt_q;
                    state_d      = ST_FETCH;
                end
            end

            default: begin
                state_d   = ST_FETCH;
                out_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FETCH;
            fetch_addr_q <= START_PC;
            drop_tgt_q   <= START_PC;
            req_en_q     <= 1'b0;
            out_vld_q    <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc_q     <= START_PC;
            buf_instr_q  <= 32'h0;
            buf_pc_q     <= START_PC;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            drop_tgt_q   <= drop_tgt_d;
            req_en_q     <= 1'b1;
            out_vld_q    <= out_vld_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

endmodule
